// File: rtl/nonce_scheduler.sv
// Batch scheduler for a bank of parallel SHA-256 workers: launches the two
// compression phases per batch, scans the final H0 lanes for a hit below target.
module nonce_scheduler #(
    parameter int NUM_WORKERS = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [31:0]               target,
    input  logic [15:0]               max_batches,
    output logic                      wk_start,
    output logic                      wk_phase_sel,
    output logic [31:0]               wk_nonce_base,
    input  logic [NUM_WORKERS-1:0]    wk_finish,
    input  logic [NUM_WORKERS*32-1:0] wk_h0,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic [31:0]               found_nonce,
    output logic [15:0]               batches_run,
    output logic                      error
);

    // state   | meaning
    // IDLE    | waiting for start
    // LAUNCH2 | start pulse, second-block compression
    // WAIT2   | collecting phase-2 finish flags
    // LAUNCH3 | start pulse, final hash
    // WAIT3   | collecting phase-3 finish flags
    // CHECK   | scan registered H0 lanes, advance batch
    // DONE    | completion pulse
    typedef enum logic [2:0] {IDLE, LAUNCH2, WAIT2, LAUNCH3, WAIT3, CHECK, DONE} state_t;

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int IW = (NUM_WORKERS < 2) ? 1 : $clog2(NUM_WORKERS);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    state_t                      state_q, state_d;
    logic [NUM_WORKERS-1:0]      mask_q, mask_d;
    logic [TW-1:0]               timer_q, timer_d;
    logic                        abort_q, abort_d;
    logic [31:0]                 target_q, target_d;
    logic [15:0]                 maxb_q, maxb_d;
    logic [31:0]                 base_q, base_d;
    logic                        found_q, found_d;
    logic [31:0]                 fnonce_q, fnonce_d;
    logic [15:0]                 brun_q, brun_d;
    logic                        error_q, error_d;
    logic [NUM_WORKERS-1:0][31:0] h0_q;
    logic                        h0_load;

    logic                        all_done;
    logic                        hit_any;
    logic [IW-1:0]               hit_idx;
    logic [15:0]                 brun_inc;

    assign all_done = &(mask_q | wk_finish);
    assign brun_inc = brun_q + 16'd1;

    // Walk downward so the lowest hitting index wins.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
            if (h0_q[i] < target_q) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        timer_d  = timer_q;
        abort_d  = abort_q | (abort && state_q != IDLE);
        target_d = target_q;
        maxb_d   = maxb_q;
        base_d   = base_q;
        found_d  = found_q;
        fnonce_d = fnonce_q;
        brun_d   = brun_q;
        error_d  = error_q;
        h0_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    found_d  = 1'b0;
                    fnonce_d = '0;
                    brun_d   = '0;
                    error_d  = 1'b0;
                    base_d   = '0;
                    abort_d  = 1'b0;
                    mask_d   = '0;
                    target_d = target;
                    maxb_d   = max_batches;
                    state_d  = (max_batches == 16'd0) ? DONE : LAUNCH2;
                end
            end
            LAUNCH2, LAUNCH3: begin
                mask_d  = '0;
                timer_d = TMR_LOAD;
                state_d = (state_q == LAUNCH2) ? WAIT2 : WAIT3;
            end
            WAIT2, WAIT3: begin
                mask_d = mask_q | wk_finish;
                if (all_done) begin
                    state_d = (state_q == WAIT2) ? LAUNCH3 : CHECK;
                    h0_load = (state_q == WAIT3);
                end else if (timer_q == '0) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            CHECK: begin
                brun_d = brun_inc;
                if (hit_any) begin
                    found_d  = 1'b1;
                    fnonce_d = base_q + 32'(hit_idx);
                    state_d  = DONE;
                end else begin
                    base_d  = base_q + 32'(NUM_WORKERS);
                    state_d = (brun_inc == maxb_q || abort_q) ? DONE : LAUNCH2;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            timer_q  <= '0;
            abort_q  <= 1'b0;
            target_q <= '0;
            maxb_q   <= '0;
            base_q   <= '0;
            found_q  <= 1'b0;
            fnonce_q <= '0;
            brun_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            timer_q  <= timer_d;
            abort_q  <= abort_d;
            target_q <= target_d;
            maxb_q   <= maxb_d;
            base_q   <= base_d;
            found_q  <= found_d;
            fnonce_q <= fnonce_d;
            brun_q   <= brun_d;
            error_q  <= error_d;
        end
    end

    // Lane snapshot is only consumed in CHECK, so it needs no reset.
    always_ff @(posedge clk) begin
        if (h0_load) h0_q <= wk_h0;
    end

    assign wk_start      = (state_q == LAUNCH2) || (state_q == LAUNCH3);
    assign wk_phase_sel  = (state_q == LAUNCH3) || (state_q == WAIT3);
    assign wk_nonce_base = base_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign found         = found_q;
    assign found_nonce   = fnonce_q;
    assign batches_run   = brun_q;
    assign error         = error_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler with a simple worker-bank model that
// answers each start pulse with staggered finish pulses (low half, then high half).
module tb_nonce_scheduler;

    localparam int NW = 16;
    localparam int TO = 255;

    logic            clk = 1'b0;
    logic            reset, start, abort;
    logic [31:0]     target;
    logic [15:0]     max_batches;
    logic            wk_start, wk_phase_sel;
    logic [31:0]     wk_nonce_base;
    logic [NW-1:0]   wk_finish = '0;
    logic [NW*32-1:0] wk_h0;
    logic            busy, done, found;
    logic [31:0]     found_nonce;
    logic [15:0]     batches_run;
    logic            error;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int lat_lo = 2;
    int lat_hi = 4;
    logic [NW-1:0] blk = '0;
    int  wcnt = 0;
    bit  wact = 1'b0;
    int  n_start = 0;
    int  n_p0 = 0;
    int  n_p1 = 0;
    int  p0_cyc[$];

    logic [NW-1:0] hit_lanes = '0;
    int            hit_p1 = -1;
    logic [31:0]   hit_val = 32'h0;
    logic [31:0]   miss_val = 32'h0;

    nonce_scheduler #(.NUM_WORKERS(NW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .target(target), .max_batches(max_batches),
        .wk_start(wk_start), .wk_phase_sel(wk_phase_sel), .wk_nonce_base(wk_nonce_base),
        .wk_finish(wk_finish), .wk_h0(wk_h0),
        .busy(busy), .done(done), .found(found), .found_nonce(found_nonce),
        .batches_run(batches_run), .error(error)
    );

    always #5 clk = ~clk;

    // Worker bank: runs on the falling edge so finish flags are stable at the rising edge.
    always @(negedge clk) begin
        if (reset) begin
            wact = 1'b0;
            wk_finish = '0;
        end else if (wk_start) begin
            n_start++;
            if (wk_phase_sel) n_p1++;
            else begin
                n_p0++;
                p0_cyc.push_back(cyc);
            end
            wact = 1'b1;
            wcnt = 0;
            wk_finish = '0;
        end else if (wact) begin
            wcnt++;
            wk_finish = '0;
            if (wcnt == lat_lo) wk_finish = wk_finish | ({8'h00, 8'hFF} & ~blk);
            if (wcnt == lat_hi) wk_finish = wk_finish | ({8'hFF, 8'h00} & ~blk);
            if (wcnt >= lat_lo && wcnt >= lat_hi) wact = 1'b0;
        end else begin
            wk_finish = '0;
        end
        cyc++;
    end

    always_comb begin
        for (int n = 0; n < NW; n++)
            wk_h0[n*32 +: 32] = (n_p1 == hit_p1 && hit_lanes[n]) ? hit_val : miss_val;
    end

    task automatic do_start(input logic [15:0] mb, input logic [31:0] tg);
        start = 1'b1;
        max_batches = mb;
        target = tg;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok, output int dcyc);
        ok = 1'b0;
        dcyc = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #2;
            if (done) begin
                ok = 1'b1;
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_p1(input int cnt, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (n_p1 >= cnt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %0b want 0", done); end
        checks++; if (wk_start !== 1'b0) begin errors++; $display("FAIL reset wk_start: got %0b want 0", wk_start); end
        checks++; if (wk_phase_sel !== 1'b0) begin errors++; $display("FAIL reset wk_phase_sel: got %0b want 0", wk_phase_sel); end
        checks++; if (wk_nonce_base !== 32'd0) begin errors++; $display("FAIL reset wk_nonce_base: got %0h want 0", wk_nonce_base); end
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL reset found: got %0b want 0", found); end
        checks++; if (found_nonce !== 32'd0) begin errors++; $display("FAIL reset found_nonce: got %0h want 0", found_nonce); end
        checks++; if (batches_run !== 16'd0) begin errors++; $display("FAIL reset batches_run: got %0d want 0", batches_run); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset error: got %0b want 0", error); end
        reset = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_all_hit();
        int s0, s1, dcyc;
        bit ok;
        s0 = n_start; s1 = n_p1;
        hit_p1 = -1; hit_lanes = '0; miss_val = 32'h0000_0010;
        do_start(16'd1, 32'hFFFF_FFFF);
        checks++; if (wk_start !== 1'b1 || wk_phase_sel !== 1'b0) begin errors++; $display("FAIL all_hit launch2: got start=%0b sel=%0b want 1/0", wk_start, wk_phase_sel); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL all_hit busy: got %0b want 1", busy); end
        @(posedge clk); #2;
        checks++; if (wk_start !== 1'b0 || wk_phase_sel !== 1'b0) begin errors++; $display("FAIL all_hit wait2: got start=%0b sel=%0b want 0/0", wk_start, wk_phase_sel); end
        wait_p1(s1 + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL all_hit launch3 timeout: got none want pulse"); end
        checks++; if (wk_start !== 1'b0 || wk_phase_sel !== 1'b1) begin errors++; $display("FAIL all_hit wait3: got start=%0b sel=%0b want 0/1", wk_start, wk_phase_sel); end
        wait_done(200, ok, dcyc);
        checks++; if (!ok) begin errors++; $display("FAIL all_hit done timeout: got none want done"); end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL all_hit found: got %0b want 1", found); end
        checks++; if (found_nonce !== 32'd0) begin errors++; $display("FAIL all_hit found_nonce: got %0d want 0", found_nonce); end
        checks++; if (batches_run !== 16'd1) begin errors++; $display("FAIL all_hit batches_run: got %0d want 1", batches_run); end
        checks++; if (n_start - s0 != 2) begin errors++; $display("FAIL all_hit wk_start count: got %0d want 2", n_start - s0); end
        @(posedge clk); #2;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL all_hit idle: got done=%0b busy=%0b want 0/0", done, busy); end
    endtask

    task automatic test_hit_second();
        int s0, dcyc;
        bit ok;
        s0 = n_start;
        hit_p1 = n_p1 + 2; hit_lanes = '0; hit_lanes[5] = 1'b1; hit_lanes[9] = 1'b1;
        hit_val = 32'h0000_0800; miss_val = 32'h0000_2000;
        do_start(16'd4, 32'h0000_1000);
        // Inputs moved mid-run must not matter; a stray start must be ignored.
        target = 32'hFFFF_FFFF; max_batches = 16'd1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(200, ok, dcyc);
        checks++; if (!ok) begin errors++; $display("FAIL hit2 done timeout: got none want done"); end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL hit2 found: got %0b want 1", found); end
        checks++; if (found_nonce !== 32'd21) begin errors++; $display("FAIL hit2 found_nonce: got %0d want 21", found_nonce); end
        checks++; if (batches_run !== 16'd2) begin errors++; $display("FAIL hit2 batches_run: got %0d want 2", batches_run); end
        checks++; if (wk_nonce_base !== 32'd16) begin errors++; $display("FAIL hit2 wk_nonce_base: got %0d want 16", wk_nonce_base); end
        checks++; if (n_start - s0 != 4) begin errors++; $display("FAIL hit2 wk_start count: got %0d want 4", n_start - s0); end
        @(posedge clk); #2;
        hit_p1 = -1; hit_lanes = '0;
    endtask

    task automatic test_no_hit();
        int s0, q0, dcyc;
        bit ok;
        s0 = n_start; q0 = p0_cyc.size();
        miss_val = 32'h0000_2000;
        do_start(16'd3, 32'h0000_0010);
        wait_done(200, ok, dcyc);
        checks++; if (!ok) begin errors++; $display("FAIL nohit done timeout: got none want done"); end
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL nohit found: got %0b want 0", found); end
        checks++; if (batches_run !== 16'd3) begin errors++; $display("FAIL nohit batches_run: got %0d want 3", batches_run); end
        checks++; if (wk_nonce_base !== 32'd48) begin errors++; $display("FAIL nohit wk_nonce_base: got %0d want 48", wk_nonce_base); end
        checks++; if (n_start - s0 != 6) begin errors++; $display("FAIL nohit wk_start count: got %0d want 6", n_start - s0); end
        checks++;
        if (p0_cyc.size() < q0 + 3) begin
            errors++; $display("FAIL nohit launch record: got %0d want 3", p0_cyc.size() - q0);
        end else begin
            if (p0_cyc[q0+1] - p0_cyc[q0] != 11) begin errors++; $display("FAIL nohit batch latency: got %0d want 11", p0_cyc[q0+1] - p0_cyc[q0]); end
            checks++;
            if (dcyc - p0_cyc[q0+2] != 11) begin errors++; $display("FAIL nohit last batch to done: got %0d want 11", dcyc - p0_cyc[q0+2]); end
        end
        @(posedge clk); #2;
    endtask

    task automatic test_timeout();
        int s0, q0, dcyc;
        bit ok;
        s0 = n_start; q0 = p0_cyc.size();
        blk = '0; blk[7] = 1'b1;
        do_start(16'd2, 32'h0000_0010);
        wait_done(600, ok, dcyc);
        checks++; if (!ok) begin errors++; $display("FAIL timeout done timeout: got none want done"); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout error: got %0b want 1", error); end
        checks++; if (batches_run !== 16'd0) begin errors++; $display("FAIL timeout batches_run: got %0d want 0", batches_run); end
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL timeout found: got %0b want 0", found); end
        checks++; if (n_start - s0 != 1) begin errors++; $display("FAIL timeout wk_start count: got %0d want 1", n_start - s0); end
        checks++;
        if (p0_cyc.size() < q0 + 1) begin
            errors++; $display("FAIL timeout launch record: got 0 want 1");
        end else if (dcyc - p0_cyc[q0] != TO + 1) begin
            errors++; $display("FAIL timeout duration: got %0d want %0d", dcyc - p0_cyc[q0], TO + 1);
        end
        blk = '0;
        @(posedge clk); #2;
    endtask

    task automatic test_abort();
        int s0, s1, dcyc;
        bit ok;
        s0 = n_start; s1 = n_p1;
        miss_val = 32'h0000_2000;
        do_start(16'd10, 32'h0000_0010);
        wait_p1(s1 + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort launch3 timeout: got none want pulse"); end
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        wait_done(200, ok, dcyc);
        checks++; if (!ok) begin errors++; $display("FAIL abort done timeout: got none want done"); end
        checks++; if (batches_run !== 16'd1) begin errors++; $display("FAIL abort batches_run: got %0d want 1", batches_run); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL abort error: got %0b want 0", error); end
        checks++; if (n_start - s0 != 2) begin errors++; $display("FAIL abort wk_start count: got %0d want 2", n_start - s0); end
        @(posedge clk); #2;
        // Abort latch must not survive into the next search.
        do_start(16'd2, 32'h0000_0010);
        wait_done(200, ok, dcyc);
        checks++; if (!ok || batches_run !== 16'd2) begin errors++; $display("FAIL abort latch cleared: got %0d want 2", batches_run); end
        @(posedge clk); #2;
        s0 = n_start;
        do_start(16'd0, 32'h0000_0010);
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL zero batches done: got done=%0b busy=%0b want 1/1", done, busy); end
        checks++; if (batches_run !== 16'd0) begin errors++; $display("FAIL zero batches batches_run: got %0d want 0", batches_run); end
        @(posedge clk); #2;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero batches idle: got done=%0b busy=%0b want 0/0", done, busy); end
        checks++; if (n_start - s0 != 0) begin errors++; $display("FAIL zero batches wk_start count: got %0d want 0", n_start - s0); end
    endtask

    task automatic test_reset_mid();
        int s1, dcyc;
        bit ok;
        s1 = n_p1;
        miss_val = 32'h0000_2000;
        do_start(16'd3, 32'h0000_0010);
        wait_p1(s1 + 2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid batch1 launch3 timeout: got none want pulse"); end
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || wk_start !== 1'b0 || wk_phase_sel !== 1'b0) begin errors++; $display("FAIL rstmid ctrl: got busy=%0b done=%0b start=%0b sel=%0b want 0", busy, done, wk_start, wk_phase_sel); end
        checks++; if (wk_nonce_base !== 32'd0) begin errors++; $display("FAIL rstmid wk_nonce_base: got %0d want 0", wk_nonce_base); end
        checks++; if (batches_run !== 16'd0) begin errors++; $display("FAIL rstmid batches_run: got %0d want 0", batches_run); end
        checks++; if (found !== 1'b0 || found_nonce !== 32'd0 || error !== 1'b0) begin errors++; $display("FAIL rstmid result: got found=%0b nonce=%0d err=%0b want 0", found, found_nonce, error); end
        reset = 1'b0;
        @(posedge clk); #2;
        hit_p1 = n_p1 + 1; hit_lanes = '0; hit_lanes[3] = 1'b1; hit_val = 32'h0000_0005;
        do_start(16'd1, 32'h0000_0100);
        wait_done(200, ok, dcyc);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid rerun done timeout: got none want done"); end
        checks++; if (found !== 1'b1 || found_nonce !== 32'd3) begin errors++; $display("FAIL rstmid rerun hit: got found=%0b nonce=%0d want 1/3", found, found_nonce); end
        checks++; if (batches_run !== 16'd1 || error !== 1'b0) begin errors++; $display("FAIL rstmid rerun status: got runs=%0d err=%0b want 1/0", batches_run, error); end
        @(posedge clk); #2;
        hit_p1 = -1; hit_lanes = '0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        target = 32'h0;
        max_batches = 16'h0;
        test_reset();
        test_all_hit();
        test_hit_second();
        test_no_hit();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nonce_scheduler.md
NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 SHALL have parameter NUM_WORKERS, default 16: number of sha256 workers driven in parallel.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles allowed in one wait state.
REQ-003 Port clk  in  1: single clock; all logic on its rising edge.
REQ-004 Port reset  in  1: synchronous reset, active high.
REQ-005 Port start  in  1: begin a search; sampled only in IDLE.
REQ-006 Port abort  in  1: request early stop; sampled while busy.
REQ-007 Port target  in  32: hit threshold; a hit is H0 < target, unsigned.
REQ-008 Port max_batches  in  16: number of batches to run; sampled on start.
REQ-009 Port wk_start  out  1: one-cycle start pulse to all workers.
REQ-010 Port wk_phase_sel  out  1: 0 = second-block compression, 1 = final hash.
REQ-011 Port wk_nonce_base  out  32: base nonce of the current batch; worker n uses base+n.
REQ-012 Port wk_finish  in  NUM_WORKERS: per-worker finish flag, pulse or level.
REQ-013 Port wk_h0  in  NUM_WORKERS*32: per-worker final H0; worker n in bits [32n+31:32n].
REQ-014 Port busy  out  1: high in every state except IDLE.
REQ-015 Port done  out  1: one-cycle completion pulse.
REQ-016 Port found  out  1: a hit occurred; valid from done until the next start.
REQ-017 Port found_nonce  out  32: nonce of the hit; valid when found=1.
REQ-018 Port batches_run  out  16: number of batches completed.
REQ-019 Port error  out  1: a wait state timed out; valid from done until the next start.

Function
REQ-020 States SHALL be IDLE, LAUNCH2, WAIT2, LAUNCH3, WAIT3, CHECK, DONE.
REQ-021 In IDLE with start=1, SHALL clear found, found_nonce, batches_run, error, wk_nonce_base, the abort latch and the finish mask.
- Then SHALL go to DONE if max_batches==0, else to LAUNCH2.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 LAUNCH2 SHALL assert wk_start for exactly one cycle with wk_phase_sel=0, clear the finish mask and the timer, and go to WAIT2.
REQ-024 WAIT2/WAIT3 behaviour:
- SHALL OR wk_finish into a sticky NUM_WORKERS-bit mask.
- SHALL advance when the mask combined with the current wk_finish is all ones.
- WAIT2 advances to LAUNCH3; WAIT3 advances to CHECK.
REQ-025 LAUNCH3 SHALL assert wk_start for exactly one cycle with wk_phase_sel=1, clear the mask and the timer, and go to WAIT3.
REQ-026 wk_phase_sel SHALL hold its value from the launch cycle through the following wait state.
REQ-027 On leaving WAIT3, SHALL register all wk_h0 lanes in that same cycle; CHECK SHALL use only these registered values.
REQ-028 CHECK, when a hit exists:
- SHALL select the lowest worker index i with a hit.
- SHALL set found=1, found_nonce=wk_nonce_base+i (mod 2^32), increment batches_run, and go to DONE.
REQ-029 CHECK, when no hit exists:
- SHALL increment batches_run and add NUM_WORKERS to wk_nonce_base (wraps mod 2^32).
- SHALL go to DONE if the new batches_run==max_batches or the abort latch is set, else to LAUNCH2.
REQ-030 abort=1 while busy SHALL set a sticky latch; the latch SHALL take effect only at CHECK, so the in-flight batch always completes.
REQ-031 Wait-state timer SHALL count cycles spent in the current wait state.
- On reaching TIMEOUT without completion, SHALL set error=1 and go to DONE.
- found SHALL be left unchanged and batches_run SHALL not increment.
REQ-032 DONE SHALL assert done for one cycle and go to IDLE.
REQ-033 max_batches and target SHALL be captured on start; later input changes SHALL have no effect until the next start.
REQ-034 Batch latency without a hit SHALL be 3 + W2 + W3 cycles, where W2 and W3 are the cycles spent in WAIT2 and WAIT3.

Reset
REQ-035 reset=1 SHALL, at the next edge, force IDLE from any state, including mid-wait.
REQ-036 On reset, wk_start, wk_phase_sel, wk_nonce_base, busy, done, found, found_nonce, batches_run, error, the mask, the timer and the abort latch SHALL all become 0.
REQ-037 A start after reset SHALL operate normally with no residue from the interrupted run.

Verification
REQ-038 max_batches=1, target=FFFFFFFF, all workers H0=00000010 -> found=1, found_nonce=0, batches_run=1, exactly 2 wk_start pulses.
REQ-039 target=00001000; batch0 no hits; batch1 workers 5 and 9 give H0=00000800 -> found_nonce=21, batches_run=2.
REQ-040 max_batches=3, no hits -> done with found=0, batches_run=3, final wk_nonce_base=48, 6 wk_start pulses.
REQ-041 Worker 7 never finishes in WAIT2 -> error=1, done after TIMEOUT cycles in WAIT2, batches_run=0.
REQ-042 max_batches=10, abort pulsed during batch0 WAIT3 -> done after CHECK, batches_run=1; max_batches=0 -> done 2 cycles after start, no wk_start.
REQ-043 reset asserted mid-WAIT3 -> all outputs 0 next cycle; a new start then produces a correct result.
